// File: rtl/gpio_controller_v2.sv
// gpio_controller_v2: parametrised femto-bus GPIO with synced inputs, SET/CLR/TGL writes and W1C edge interrupts (ports: clk rst dir i o irq addr w_rb acc rdata wdata req resp fault)
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif
module gpio_controller_v2 #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [WIDTH-1:0]          dir,
  input  logic [WIDTH-1:0]          i,
  output logic [WIDTH-1:0]          o,
  output logic                      irq,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     rdata,
  input  logic [`BUS_WIDTH-1:0]     wdata,
  input  logic                      req,
  output logic                      resp,
  output logic                      fault
);
  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] dir_r, irise, ifall, ip, s, p, rise, fall, clr, wd, rd_val;
  logic [2:0] idx;
  logic valid, wr, rd, unused;
  assign unused = ^{wdata, addr};
  assign idx = addr[4:2];
  assign wd = wdata[WIDTH-1:0];
  assign s = sync[SYNC_STAGES-1];
  assign valid = ((addr >> 5) == '0) && (addr[1:0] == 2'b00) && (acc == `BUS_ACC_4B) && (w_rb || idx < 3'd2 || idx > 3'd4);
  assign fault = req & ~valid;
  assign wr = req & valid & w_rb;
  assign rd = req & valid & ~w_rb;
  assign rise = s & ~p & irise;
  assign fall = ~s & p & ifall;
  assign clr = (wr && idx == 3'd7) ? wd : '0;
  assign irq = |ip;
  always_comb begin
    rd_val = idx == 3'd0 ? (o & dir_r) | (s & ~dir_r) :
             idx == 3'd1 ? dir_r :
             idx == 3'd5 ? irise :
             idx == 3'd6 ? ifall : ip;
    for (int k = 0; k < WIDTH; k++) dir[k] = dir_r[k] ? `IOR_DIR_OUT : `IOR_DIR_IN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
      p <= '0;
      o <= '0;
      dir_r <= '0;
      irise <= '0;
      ifall <= '0;
      ip <= '0;
      rdata <= '0;
      resp <= 1'b0;
    end else begin
      sync[0] <= i;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      p <= s;
      resp <= req & valid;
      // set terms are ORed after the clear mask so a coincident edge wins
      ip <= (ip & ~clr) | rise | fall;
      if (rd) rdata <= `BUS_WIDTH'(rd_val);
      if (wr) begin
        o <= idx == 3'd0 ? wd : idx == 3'd2 ? o | wd : idx == 3'd3 ? o & ~wd : idx == 3'd4 ? o ^ wd : o;
        dir_r <= idx == 3'd1 ? wd : dir_r;
        irise <= idx == 3'd5 ? wd : irise;
        ifall <= idx == 3'd6 ? wd : ifall;
      end
    end
  end
endmodule
